// File: rtl/hungry_pkg.sv
// Shared definitions for the hungry_core game path: FSM state encoding,
// BCD helper constants, prescaler sizing and the per-round time helper.
package hungry_pkg;

    // Game controller state encoding (3-bit, IDLE must stay 0)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_ROUND_END = 3'd4;
    localparam logic [2:0] ST_WIN       = 3'd5;
    localparam logic [2:0] ST_LOSE      = 3'd6;

    // BCD digit helpers
    localparam logic [3:0] BCD_ZERO = 4'h0;
    localparam logic [3:0] BCD_ONE  = 4'h1;
    localparam logic [3:0] BCD_NINE = 4'h9;

    // 50 MHz board clock divided down to one countdown second
    localparam int DEFAULT_TICK_DIV = 50000000;
    localparam int PRESCALE_W       = 26;

    // Tens digit for a given round: start value minus one step per completed
    // round, never below the floor. A drop larger than the start value would
    // wrap in 4 bits, so that case clamps to the floor as well.
    function automatic logic [3:0] round_tens(input logic [3:0] round,
                                              input logic [3:0] start_tens,
                                              input logic [3:0] step_tens,
                                              input logic [3:0] min_tens);
        logic [7:0] drop;
        drop = ({4'h0, round} - 8'd1) * {4'h0, step_tens};
        if (drop > {4'h0, start_tens})
            return min_tens;
        else if (({4'h0, start_tens} - drop) < {4'h0, min_tens})
            return min_tens;
        else
            return start_tens - drop[3:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Countdown-second prescaler: counts enabled cycles 0..DIV-1 and flags the
// last one. Holds its value while disabled, clears on clr.
module tick_prescaler
    import hungry_pkg::*;
#(
    parameter int DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(DIV - 1);

    logic [PRESCALE_W-1:0] count;

    // Advance the counter while enabled, wrapping after the last cycle
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en) begin
            if (count == LAST)
                count <= '0;
            else
                count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// Round controller for the hungry_core countdown display path. Loads the
// per-round start time, paces the 1 Hz decrement and decides win/lose.
// Optional feature macro: ROUND_TIMER_PAUSE_EN (adds the PAUSE state).
module round_timer_ctrl
    import hungry_pkg::*;
#(
    parameter int TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int ROUND0_TENS = 6,
    parameter int STEP_TENS   = 1,
    parameter int MIN_TENS    = 2,
    parameter int MAX_ROUND   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       goal_met,
    input  logic       cd_zero,
    output logic       cd_load,
    output logic [7:0] cd_load_val,
    output logic       cd_tick,
    output logic [3:0] round_bcd,
    output logic       running,
    output logic       paused,
    output logic       win,
    output logic       game_over
);

    localparam logic [3:0] R0_TENS   = 4'(ROUND0_TENS);
    localparam logic [3:0] S_TENS    = 4'(STEP_TENS);
    localparam logic [3:0] M_TENS    = 4'(MIN_TENS);
    localparam logic [3:0] LAST_RND  = 4'(MAX_ROUND);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] round_q;
    logic [3:0] next_round;
    logic [7:0] load_val_q;
    logic       pre_tick;

`ifndef ROUND_TIMER_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    // Next-state and next-round decision for the game sequence
    always_comb begin
        next_state = state;
        next_round = round_q;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    next_state = ST_LOAD;
                    next_round = BCD_ONE;
                end
            end
            ST_LOAD: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (cd_zero)
                    next_state = ST_ROUND_END;
`ifdef ROUND_TIMER_PAUSE_EN
                else if (pause)
                    next_state = ST_PAUSE;
`endif
            end
`ifdef ROUND_TIMER_PAUSE_EN
            ST_PAUSE: begin
                if (pause)
                    next_state = ST_RUN;
            end
`endif
            ST_ROUND_END: begin
                if (!goal_met)
                    next_state = ST_LOSE;
                else if (round_q == LAST_RND)
                    next_state = ST_WIN;
                else begin
                    next_round = round_q + 4'd1;
                    next_state = ST_LOAD;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, round number and load value registers; the load value is
    // computed on the way into LOAD so it is stable for the whole strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            round_q    <= BCD_ZERO;
            load_val_q <= 8'h00;
        end else begin
            state   <= next_state;
            round_q <= next_round;
            if (next_state == ST_LOAD)
                load_val_q <= {round_tens(next_round, R0_TENS, S_TENS, M_TENS), 4'h0};
        end
    end

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ST_LOAD),
        .en    (state == ST_RUN),
        .tick  (pre_tick)
    );

    // The zero flag suppresses the tick so the datapath never decrements
    // below 00 in the cycle the round is being closed.
    assign cd_tick     = pre_tick && !cd_zero;
    assign cd_load     = (state == ST_LOAD);
    assign cd_load_val = load_val_q;
    assign round_bcd   = round_q;
    assign running     = (state == ST_RUN);
    assign win         = (state == ST_WIN);
    assign game_over   = (state == ST_LOSE);
`ifdef ROUND_TIMER_PAUSE_EN
    assign paused      = (state == ST_PAUSE);
`else
    assign paused      = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Self-checking bench for round_timer_ctrl with TICK_DIV = 4.
// Pause sequences follow the ROUND_TIMER_PAUSE_EN macro of the build.
module tb_round_timer_ctrl;

    localparam int TICK_DIV = 4;

    typedef struct packed {
        logic       cd_load;
        logic [7:0] cd_load_val;
        logic       cd_tick;
        logic [3:0] round_bcd;
        logic       running;
        logic       paused;
        logic       win;
        logic       game_over;
    } out_t;

    typedef struct packed {
        logic reset;
        logic start;
        logic pause;
        logic goal_met;
        logic cd_zero;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, start, pause, goal_met, cd_zero;
    logic       zero_drv;
    logic       use_model = 1'b0;
    logic       tick_chk = 1'b0;
    logic [7:0] cd_val = 8'h00;
    logic       cd_load, cd_tick, running, paused, win, game_over;
    logic [7:0] cd_load_val;
    logic [3:0] round_bcd;

    int vectors = 0;
    int miscompares = 0;
    int run_cnt = 0;

    vec_t vecs[25];

    round_timer_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ROUND0_TENS (6),
        .STEP_TENS   (1),
        .MIN_TENS    (2),
        .MAX_ROUND   (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .goal_met    (goal_met),
        .cd_zero     (cd_zero),
        .cd_load     (cd_load),
        .cd_load_val (cd_load_val),
        .cd_tick     (cd_tick),
        .round_bcd   (round_bcd),
        .running     (running),
        .paused      (paused),
        .win         (win),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    assign cd_zero = use_model ? (cd_val == 8'h00) : zero_drv;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h00;
        else if (v[3:0] == 4'h0)
            return {v[7:4] - 4'h1, 4'h9};
        else
            return {v[7:4], v[3:0] - 4'h1};
    endfunction

    // Behavioural BCD countdown datapath driven by the controller strobes
    always @(posedge clk) begin
        if (cd_load)
            cd_val <= cd_load_val;
        else if (cd_tick)
            cd_val <= bcd_dec(cd_val);
    end

    // Tick spacing: every tick must land on the TICK_DIV-th RUN cycle
    always @(posedge clk) begin
        if (cd_load)
            run_cnt = 0;
        else if (running) begin
            run_cnt = run_cnt + 1;
            if (cd_tick) begin
                if (tick_chk) begin
                    vectors = vectors + 1;
                    if (run_cnt != TICK_DIV) begin
                        miscompares = miscompares + 1;
                        $display("[TB] FAIL tick_spacing: got %0d run cycles, expected %0d", run_cnt, TICK_DIV);
                    end
                end
                run_cnt = 0;
            end
        end
    end

    function automatic out_t mk_out(input logic ld, input logic [7:0] v, input logic tk,
                                    input logic [3:0] rd, input logic rn, input logic pz,
                                    input logic w, input logic go);
        out_t o;
        o = '{cd_load: ld, cd_load_val: v, cd_tick: tk, round_bcd: rd,
              running: rn, paused: pz, win: w, game_over: go};
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic s, input logic p,
                                    input logic g, input logic z, input out_t e);
        vec_t v;
        v = '{reset: r, start: s, pause: p, goal_met: g, cd_zero: z, exp: e};
        return v;
    endfunction

    // Present one cycle of inputs at the falling edge, settle before checking
    task automatic apply_stimulus(input logic r, input logic s, input logic p,
                                  input logic g, input logic z);
        @(negedge clk);
        reset    = r;
        start    = s;
        pause    = p;
        goal_met = g;
        zero_drv = z;
        #1;
    endtask

    task automatic check_output(input string name, input out_t exp);
        out_t act;
        act = '{cd_load: cd_load, cd_load_val: cd_load_val, cd_tick: cd_tick,
                round_bcd: round_bcd, running: running, paused: paused,
                win: win, game_over: game_over};
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %h expected %h (ld,val,tick,round,run,pause,win,over)",
                     name, act, exp);
        end
    endtask

    task automatic check_field(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded wait for cd_load (0), win (1) or game_over (2)
    task automatic wait_for(input int which, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < bound && !hit; k++) begin
            case (which)
                0: hit = cd_load;
                1: hit = win;
                default: hit = game_over;
            endcase
            if (!hit) begin
                @(negedge clk);
                #1;
            end
        end
        if (!hit) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: timeout after %0d cycles, expected event", name, bound);
        end
    endtask

    task automatic do_reset();
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
    endtask

    out_t idle0, ld60, ld50;

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; goal_met = 1'b0; zero_drv = 1'b0;

        idle0 = mk_out(0, 8'h00, 0, 4'd0, 0, 0, 0, 0);
        ld60  = mk_out(1, 8'h60, 0, 4'd1, 0, 0, 0, 0);
        ld50  = mk_out(1, 8'h50, 0, 4'd2, 0, 0, 0, 0);

        // Each row: inputs presented in a cycle and the outputs seen in that same cycle
        vecs[0]  = mk_vec(0, 0, 0, 0, 0, idle0);
        vecs[1]  = mk_vec(0, 1, 0, 0, 0, idle0);
        vecs[2]  = mk_vec(0, 0, 0, 0, 0, ld60);
        vecs[3]  = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[4]  = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[5]  = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[6]  = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 1, 4'd1, 1, 0, 0, 0));
        vecs[7]  = mk_vec(0, 1, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[8]  = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[9]  = mk_vec(0, 0, 0, 0, 1, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[10] = mk_vec(0, 0, 0, 1, 0, mk_out(0, 8'h60, 0, 4'd1, 0, 0, 0, 0));
        vecs[11] = mk_vec(0, 0, 0, 0, 0, ld50);
        vecs[12] = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 1, 0, 0, 0));
        vecs[13] = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 1, 0, 0, 0));
        vecs[14] = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 1, 0, 0, 0));
        vecs[15] = mk_vec(0, 0, 0, 0, 1, mk_out(0, 8'h50, 0, 4'd2, 1, 0, 0, 0));
        vecs[16] = mk_vec(0, 1, 0, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 0, 0, 0, 0));
        vecs[17] = mk_vec(0, 0, 1, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 0, 0, 0, 1));
        vecs[18] = mk_vec(0, 1, 0, 0, 0, mk_out(0, 8'h50, 0, 4'd2, 0, 0, 0, 1));
        vecs[19] = mk_vec(0, 0, 0, 0, 0, ld60);
        vecs[20] = mk_vec(0, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[21] = mk_vec(1, 0, 0, 0, 0, mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        vecs[22] = mk_vec(0, 0, 0, 0, 0, idle0);
        vecs[23] = mk_vec(0, 0, 1, 1, 1, idle0);
        vecs[24] = mk_vec(0, 0, 0, 0, 0, idle0);

        do_reset();
        for (int i = 0; i < 25; i++) begin
            apply_stimulus(vecs[i].reset, vecs[i].start, vecs[i].pause,
                           vecs[i].goal_met, vecs[i].cd_zero);
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Pause handling: pause raised while the prescaler reads 1 holds it at 2
        do_reset();
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("pz_load", ld60);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("pz_run_c0", mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("pz_run_c1", mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
`ifdef ROUND_TIMER_PAUSE_EN
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 0, 0, 0, 1);
            check_output($sformatf("pz_hold%0d", i), mk_out(0, 8'h60, 0, 4'd1, 0, 1, 0, 0));
        end
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("pz_resume", mk_out(0, 8'h60, 0, 4'd1, 0, 1, 0, 0));
`endif
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("pz_run_c2", mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("pz_run_c3", mk_out(0, 8'h60, 1, 4'd1, 1, 0, 0, 0));
        apply_stimulus(0, 0, 1, 0, 1);
        check_output("pz_zero_and_pause", mk_out(0, 8'h60, 0, 4'd1, 1, 0, 0, 0));
        apply_stimulus(0, 0, 0, 1, 0);
        check_output("pz_round_end", mk_out(0, 8'h60, 0, 4'd1, 0, 0, 0, 0));
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("pz_next_load", ld50);

        // Full game against the countdown model: every round won up to round 9
        do_reset();
        use_model = 1'b1;
        tick_chk  = 1'b1;
        apply_stimulus(0, 1, 0, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        for (int r = 1; r <= 9; r++) begin
            wait_for(0, 600, $sformatf("win_load_r%0d", r));
            check_field($sformatf("win_round_r%0d", r), int'(round_bcd), r);
            check_field($sformatf("win_val_r%0d", r), int'(cd_load_val),
                        (r <= 5) ? ((7 - r) * 16) : 8'h20);
            apply_stimulus(0, 0, 0, 1, 0);
        end
        wait_for(1, 600, "win_wait");
        check_field("win_flag", int'(win), 1);
        check_field("win_round", int'(round_bcd), 9);

        // Second game from WIN: lose in round 3, then restart
        apply_stimulus(0, 1, 0, 1, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        for (int r = 1; r <= 3; r++) begin
            wait_for(0, 600, $sformatf("lose_load_r%0d", r));
            check_field($sformatf("lose_round_r%0d", r), int'(round_bcd), r);
            apply_stimulus(0, 0, 0, (r < 3) ? 1'b1 : 1'b0, 0);
        end
        wait_for(2, 600, "lose_wait");
        check_field("lose_flag", int'(game_over), 1);
        check_field("lose_round", int'(round_bcd), 3);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        wait_for(0, 10, "restart_load");
        check_output("restart_load_vals", ld60);
        tick_chk  = 1'b0;
        use_model = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
